// File: rtl/shift_pkg.sv
// Shared encodings and types for the shift arbiter slice: op codes, FSM states,
// port identifiers.
package shift_pkg;

   localparam int NUM_PORTS = 2;

   localparam logic [1:0] SHIFT_SLL = 2'd0;
   localparam logic [1:0] SHIFT_SRL = 2'd1;
   localparam logic [1:0] SHIFT_SRA = 2'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      HOLD = 2'd2
   } state_t;

   typedef logic port_id_t;

   function automatic logic [NUM_PORTS-1:0] port_onehot(input port_id_t p);
      return p ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/response bundle between the two requesters and the shift arbiter.
// master = requester side, slave = arbiter side.
interface shift_arbiter_if #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
);

   logic [1:0]           req_valid;
   logic [1:0]           req_ready;
   logic [2*WIDTH-1:0]   req_a;
   logic [2*SHAMT_W-1:0] req_shamt;
   logic [3:0]           req_type;
   logic [1:0]           rsp_valid;
   logic [1:0]           rsp_ready;
   logic [WIDTH-1:0]     rsp_data;
   logic                 busy;

   modport master (
      output req_valid, req_a, req_shamt, req_type, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, busy
   );

   modport slave (
      input  req_valid, req_a, req_shamt, req_type, rsp_ready,
      output req_ready, rsp_valid, rsp_data, busy
   );

endinterface

// File: rtl/shift_core.sv
// Combinational barrel shifter: SLL / SRL / SRA on one operand; the reserved
// op code yields zero.
module shift_core
   import shift_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0]   i_a,
   input  logic [SHAMT_W-1:0] i_shamt,
   input  logic [1:0]         i_type,
   output logic [WIDTH-1:0]   o_r
);

   always_comb begin
      // NOTE: every output of a comb block gets a default first so no path leaves it unassigned (no latch).
      o_r = '0;
      case (i_type)
         SHIFT_SLL: o_r = i_a << i_shamt;
         SHIFT_SRL: o_r = i_a >> i_shamt;
         SHIFT_SRA: o_r = $unsigned($signed(i_a) >>> i_shamt);
         default:   o_r = '0;
      endcase
   end

endmodule

// File: rtl/shift_arbiter.sv
// Two-port arbiter in front of a single shared shifter: grant, latch, compute,
// hold the result until the owner accepts it. Define SHIFT_ARB_RR_EN for
// round-robin arbitration; otherwise port 0 has fixed priority.
module shift_arbiter
   import shift_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic           clk,
   input  logic           rst_n,
   shift_arbiter_if.slave bus
);

   if (WIDTH < 8 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
      $error("shift_arbiter: WIDTH must be a power of two >= 8");
   end

   state_t               r_state, w_state_next;
   logic [WIDTH-1:0]     r_a;
   logic [SHAMT_W-1:0]   r_shamt;
   logic [1:0]           r_type;
   port_id_t             r_owner;
   port_id_t             r_rsp_owner;
   logic [WIDTH-1:0]     r_rsp_data;
   logic [WIDTH-1:0]     w_result;
   port_id_t             w_winner;
   logic [1:0]           w_grant;
   logic                 w_grant_en;
   logic                 w_req_fire;
   logic                 w_rsp_fire;

`ifdef SHIFT_ARB_RR_EN
   port_id_t r_last;

   always_comb begin
      w_winner = (&bus.req_valid) ? ~r_last : ~bus.req_valid[0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          r_last <= 1'b0;
      else if (w_req_fire) r_last <= w_winner;
   end
`else
   always_comb begin
      w_winner = ~bus.req_valid[0];
   end
`endif

   // Holding rst_n low must keep req_ready low even though the state already reads IDLE.
   assign w_rsp_fire = (r_state == HOLD) && bus.rsp_ready[r_rsp_owner];
   assign w_grant_en = rst_n && ((r_state == IDLE) || w_rsp_fire);
   assign w_grant    = w_grant_en ? (port_onehot(w_winner) & bus.req_valid) : 2'b00;
   assign w_req_fire = |w_grant;

   shift_core #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_core (
      .i_a     (r_a),
      .i_shamt (r_shamt),
      .i_type  (r_type),
      .o_r     (w_result)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_req_fire) w_state_next = EXEC;
         EXEC:    w_state_next = HOLD;
         HOLD:    if (w_rsp_fire) w_state_next = w_req_fire ? EXEC : IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready = w_grant;
      bus.rsp_valid = (r_state == HOLD) ? port_onehot(r_rsp_owner) : 2'b00;
      bus.rsp_data  = r_rsp_data;
      bus.busy      = (r_state != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a         <= '0;
         r_shamt     <= '0;
         r_type      <= SHIFT_SLL;
         r_owner     <= 1'b0;
         r_rsp_owner <= 1'b0;
         r_rsp_data  <= '0;
      end else begin
         if (w_req_fire) begin
            r_a     <= w_winner ? bus.req_a[2*WIDTH-1:WIDTH]       : bus.req_a[WIDTH-1:0];
            r_shamt <= w_winner ? bus.req_shamt[2*SHAMT_W-1:SHAMT_W] : bus.req_shamt[SHAMT_W-1:0];
            r_type  <= w_winner ? bus.req_type[3:2]                : bus.req_type[1:0];
            r_owner <= w_winner;
         end
         if (r_state == EXEC) begin
            r_rsp_data  <= w_result;
            r_rsp_owner <= r_owner;
         end
      end
   end

   // Requesters must hold valid and payload steady until their request fires.
   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_req_hold
      a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
         (bus.req_valid[gi] && !bus.req_ready[gi]) |=>
            (bus.req_valid[gi]
             && $stable(bus.req_a[gi*WIDTH +: WIDTH])
             && $stable(bus.req_shamt[gi*SHAMT_W +: SHAMT_W])
             && $stable(bus.req_type[gi*2 +: 2])));
   end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: reset, op table, hold stability, contention,
// back-to-back throughput and reset in the middle of an operation.
`timescale 1ns/1ps
module tb_shift_arbiter;
   import shift_pkg::*;

   localparam int WIDTH = 32;

`ifdef SHIFT_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   typedef struct {
      int          port;
      logic [1:0]  op;
      logic [31:0] a;
      logic [4:0]  shamt;
      logic [31:0] exp;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;
   int   exp_last = 0;
   vec_t vecs[11];

   shift_arbiter_if #(.WIDTH(WIDTH)) bus();

   shift_arbiter #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [1:0] oh(input int p);
      return (p != 0) ? 2'b10 : 2'b01;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int p, input logic [1:0] op, input logic [31:0] a, input logic [4:0] sh);
      bus.req_a[p*WIDTH +: WIDTH] = a;
      bus.req_shamt[p*5 +: 5]     = sh;
      bus.req_type[p*2 +: 2]      = op;
   endtask

   // Starts at posedge+1; returns at the negedge where req_ready[p] is seen high.
   task automatic wait_grant(input int p, input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.req_ready[p] && n < 20) begin
         tick();
         @(negedge clk);
         n++;
      end
      check(name, 32'(bus.req_ready[p]), 32'd1);
   endtask

   // Starts at a negedge; serves every pending request until the block is idle.
   task automatic drain(input string name);
      logic [1:0] fired;
      int n;
      n = 0;
      bus.rsp_ready = 2'b11;
      #1;
      while ((bus.req_valid != 2'b00 || bus.busy) && n < 30) begin
         fired = bus.req_valid & bus.req_ready;
         tick();
         bus.req_valid = bus.req_valid & ~fired;
         @(negedge clk);
         n++;
      end
      bus.rsp_ready = 2'b00;
      check(name, 32'(n < 30), 32'd1);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      set_req(v.port, v.op, v.a, v.shamt);
      bus.req_valid[v.port] = 1'b1;
      wait_grant(v.port, $sformatf("vec%0d_grant", idx));
      tick();
      bus.req_valid[v.port] = 1'b0;
      exp_last = v.port;
      @(negedge clk);
      check($sformatf("vec%0d_exec_rsp_valid", idx), 32'(bus.rsp_valid), 32'd0);
      tick();
      @(negedge clk);
      check($sformatf("vec%0d_rsp_valid", idx), 32'(bus.rsp_valid), 32'(oh(v.port)));
      check($sformatf("vec%0d_rsp_data", idx), bus.rsp_data, v.exp);
      bus.rsp_ready[v.port] = 1'b1;
      tick();
      bus.rsp_ready = 2'b00;
      @(negedge clk);
      check($sformatf("vec%0d_idle_busy", idx), 32'(bus.busy), 32'd0);
      tick();
   endtask

   initial begin
      logic [31:0] cont_exp [2];
      int w;

      vecs[0]  = '{0, SHIFT_SRA, 32'h8000_00F0, 5'd4,  32'hF800_000F};
      vecs[1]  = '{1, SHIFT_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000};
      vecs[2]  = '{0, SHIFT_SRL, 32'h8000_0000, 5'd31, 32'h0000_0001};
      vecs[3]  = '{1, 2'd3,      32'hDEAD_BEEF, 5'd5,  32'h0000_0000};
      vecs[4]  = '{0, SHIFT_SLL, 32'h1234_5678, 5'd0,  32'h1234_5678};
      vecs[5]  = '{1, SHIFT_SRL, 32'hA5A5_0000, 5'd0,  32'hA5A5_0000};
      vecs[6]  = '{0, SHIFT_SRA, 32'h8000_0000, 5'd0,  32'h8000_0000};
      vecs[7]  = '{1, SHIFT_SRA, 32'h7000_0000, 5'd4,  32'h0700_0000};
      vecs[8]  = '{0, SHIFT_SRA, 32'hFFFF_FF00, 5'd31, 32'hFFFF_FFFF};
      vecs[9]  = '{1, SHIFT_SLL, 32'hF000_000F, 5'd4,  32'h0000_00F0};
      vecs[10] = '{0, SHIFT_SRL, 32'hF000_000F, 5'd4,  32'h0F00_0000};

      // Reset held with both ports requesting.
      bus.req_valid = 2'b11;
      bus.req_a     = '0;
      bus.req_shamt = '0;
      bus.req_type  = '0;
      bus.rsp_ready = 2'b00;
      @(negedge clk);
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rsp_data",  bus.rsp_data,       32'd0);
      check("rst_busy",      32'(bus.busy),      32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_req_ready", 32'(bus.req_ready), RR ? 32'd2 : 32'd1);
      drain("post_rst_drain");
      tick();

      // Single op held for five cycles; non-owner rsp_ready must be ignored.
      set_req(0, SHIFT_SRA, 32'h8000_00F0, 5'd4);
      bus.req_valid[0] = 1'b1;
      wait_grant(0, "hold_grant");
      tick();
      bus.req_valid[0] = 1'b0;
      exp_last = 0;
      @(negedge clk);
      check("hold_exec_busy", 32'(bus.busy), 32'd1);
      check("hold_exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      tick();
      bus.rsp_ready = 2'b10;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("hold%0d_rsp_valid", i), 32'(bus.rsp_valid), 32'd1);
         check($sformatf("hold%0d_rsp_data", i), bus.rsp_data, 32'hF800_000F);
         tick();
      end
      bus.rsp_ready = 2'b01;
      tick();
      bus.rsp_ready = 2'b00;
      @(negedge clk);
      check("hold_release_busy", 32'(bus.busy), 32'd0);
      tick();

      for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

      // Contention: both ports valid, rsp_ready held high, back-to-back.
      set_req(0, SHIFT_SLL, 32'h0000_0001, 5'd1);
      set_req(1, SHIFT_SRL, 32'h0000_0100, 5'd4);
      cont_exp[0] = 32'h0000_0002;
      cont_exp[1] = 32'h0000_0010;
      bus.req_valid = 2'b11;
      bus.rsp_ready = 2'b11;
      w = RR ? 1 - exp_last : 0;
      @(negedge clk);
      check("cont_grant0", 32'(bus.req_ready), 32'(oh(w)));
      for (int k = 0; k < 4; k++) begin
         tick();
         @(negedge clk);
         check($sformatf("cont%0d_exec_ready", k), 32'(bus.req_ready), 32'd0);
         check($sformatf("cont%0d_exec_rsp_valid", k), 32'(bus.rsp_valid), 32'd0);
         tick();
         @(negedge clk);
         check($sformatf("cont%0d_rsp_valid", k), 32'(bus.rsp_valid), 32'(oh(w)));
         check($sformatf("cont%0d_rsp_data", k), bus.rsp_data, cont_exp[w]);
         w = RR ? 1 - w : 0;
         check($sformatf("cont%0d_next_grant", k + 1), 32'(bus.req_ready), 32'(oh(w)));
      end
      drain("cont_drain");
      tick();

      // Reset asserted while the operation is in EXEC.
      set_req(1, SHIFT_SLL, 32'h0000_0003, 5'd2);
      bus.req_valid[1] = 1'b1;
      wait_grant(1, "midrst_grant");
      tick();
      bus.req_valid[1] = 1'b0;
      #2 rst_n = 1'b0;
      @(negedge clk);
      check("midrst_busy",      32'(bus.busy),      32'd0);
      check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("midrst_rsp_data",  bus.rsp_data,       32'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check($sformatf("midrst%0d_no_rsp", i), 32'(bus.rsp_valid), 32'd0);
         check($sformatf("midrst%0d_idle", i), 32'(bus.busy), 32'd0);
         tick();
      end
      bus.req_valid = 2'b11;
      @(negedge clk);
      check("midrst_ptr_grant", 32'(bus.req_ready), RR ? 32'd2 : 32'd1);
      drain("midrst_drain");
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
